// File: rtl/alu_barrido.sv
`default_nettype none
// ============================================================================
//  Module   : alu_barrido
//  Purpose  : On-chip sweep controller for a small combinational ALU. On an
//             accepted start it latches one operand pair, steps the function
//             code F through 0..7, waits SETTLE cycles per code, samples Y,
//             reports each result with a one-cycle strobe, and finishes with
//             a done pulse plus an XOR checksum of the eight results.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    W        operand / result width (must match the ALU)
//    SETTLE   cycles F is held before Y is sampled (1..15)
//  Ports
//    clk        in   rising-edge clock
//    rst        in   asynchronous active-high reset
//    start      in   sweep request, honoured only while idle
//    a_in/b_in  in   operands latched on an accepted start
//    busy       out  high while a sweep is running
//    alu_a/b/f  out  drive the ALU inputs
//    alu_y      in   ALU result
//    res_valid  out  one-cycle strobe for a new result
//    res_f      out  F code of the reported result
//    res_y      out  sampled Y for that code
//    done       out  one-cycle sweep-complete pulse
//    checksum   out  XOR of the eight results of the last sweep
// ============================================================================
module alu_barrido #(
  parameter int W      = 4,
  parameter int SETTLE = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         busy,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_f,
  input  logic [W-1:0] alu_y,
  output logic         res_valid,
  output logic [2:0]   res_f,
  output logic [W-1:0] res_y,
  output logic         done,
  output logic [W-1:0] checksum
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Last count value of a settle window; the sample happens on this edge.
  localparam logic [3:0] C_CNT_LAST = 4'(SETTLE - 1);
  localparam logic [2:0] C_F_LAST   = 3'd7;

  state_t         state_q,  state_d;
  logic [3:0]     cnt_q,    cnt_d;
  logic           busy_q,   busy_d;
  logic [W-1:0]   a_q,      a_d;
  logic [W-1:0]   b_q,      b_d;
  logic [2:0]     f_q,      f_d;
  logic           valid_q,  valid_d;
  logic [2:0]     resf_q,   resf_d;
  logic [W-1:0]   resy_q,   resy_d;
  logic           done_q,   done_d;
  logic [W-1:0]   cks_q,    cks_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      valid_q <= 1'b0;
      resf_q  <= '0;
      resy_q  <= '0;
      done_q  <= 1'b0;
      cks_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      a_q     <= a_d;
      b_q     <= b_d;
      f_q     <= f_d;
      valid_q <= valid_d;
      resf_q  <= resf_d;
      resy_q  <= resy_d;
      done_q  <= done_d;
      cks_q   <= cks_d;
    end
  end

  always_comb begin
    // Everything holds by default; the two strobes fall back to zero.
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    a_d     = a_q;
    b_d     = b_q;
    f_d     = f_q;
    valid_d = 1'b0;
    resf_d  = resf_q;
    resy_d  = resy_q;
    done_d  = 1'b0;
    cks_d   = cks_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          f_d     = '0;
          cnt_d   = '0;
          cks_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (cnt_q != C_CNT_LAST) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          // Sample edge: F has been stable for SETTLE cycles.
          resy_d  = alu_y;
          resf_d  = f_q;
          valid_d = 1'b1;
          cks_d   = cks_q ^ alu_y;
          if (f_q != C_F_LAST) begin
            f_d   = f_q + 3'd1;
            cnt_d = '0;
          end else begin
            // Last code: F is left at 7 and the controller returns to idle,
            // where a start in this same cycle is accepted on the next edge.
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy      = busy_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_f     = f_q;
  assign res_valid = valid_q;
  assign res_f     = resf_q;
  assign res_y     = resy_q;
  assign done      = done_q;
  assign checksum  = cks_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_barrido.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_barrido
//  Purpose  : Self-checking bench for alu_barrido. Two instances share clock
//             and reset: SETTLE=2 (main sweeps, ignored start, resets) and
//             SETTLE=1 (back-to-back sweeps with start held high). Each is
//             closed through a stub ALU computing Y = (A+B+F) mod 16.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_barrido;

  logic       clk;
  logic       rst;

  // SETTLE = 2 instance
  logic       start1;
  logic [3:0] a1, b1;
  logic       busy1, valid1, done1;
  logic [3:0] alu_a1, alu_b1, y1, res_y1, cks1;
  logic [2:0] alu_f1, res_f1;

  // SETTLE = 1 instance
  logic       start2;
  logic [3:0] a2, b2;
  logic       busy2, valid2, done2;
  logic [3:0] alu_a2, alu_b2, y2, res_y2, cks2;
  logic [2:0] alu_f2, res_f2;

  assign y1 = alu_a1 + alu_b1 + {1'b0, alu_f1};
  assign y2 = alu_a2 + alu_b2 + {1'b0, alu_f2};

  alu_barrido #(.W(4), .SETTLE(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1),
    .busy(busy1), .alu_a(alu_a1), .alu_b(alu_b1), .alu_f(alu_f1),
    .alu_y(y1), .res_valid(valid1), .res_f(res_f1), .res_y(res_y1),
    .done(done1), .checksum(cks1)
  );

  alu_barrido #(.W(4), .SETTLE(1)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .a_in(a2), .b_in(b2),
    .busy(busy2), .alu_a(alu_a2), .alu_b(alu_b2), .alu_f(alu_f2),
    .alu_y(y2), .res_valid(valid2), .res_f(res_f2), .res_y(res_y2),
    .done(done2), .checksum(cks2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0]       a;
    logic [3:0]       b;
    int               ign;   // cycle in which a stray start (A=B=0) is pulsed; 0 = none
    logic [7:0][3:0]  y;     // expected res_y for F = 0..7 (element 0 = F=0)
    logic [3:0]       cks;
  } vec_t;

  vec_t tbl [5];
  int   n_tot  = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
  endtask

  task automatic chk_zero1(input string tag);
    chk({tag, " busy"},      busy1,  0);
    chk({tag, " alu_a"},     alu_a1, 0);
    chk({tag, " alu_b"},     alu_b1, 0);
    chk({tag, " alu_f"},     alu_f1, 0);
    chk({tag, " res_valid"}, valid1, 0);
    chk({tag, " res_f"},     res_f1, 0);
    chk({tag, " res_y"},     res_y1, 0);
    chk({tag, " done"},      done1,  0);
    chk({tag, " checksum"},  cks1,   0);
  endtask

  // Full SETTLE=2 sweep with a check of every output in every cycle 1..17.
  task automatic run_sweep(input vec_t v);
    int exp_f;
    bit exp_v;
    @(negedge clk);
    start1 = 1'b1; a1 = v.a; b1 = v.b;                  // cycle 0
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      exp_v = (c >= 3) && (c % 2 == 1);
      exp_f = (c - 1) / 2;
      if (exp_f > 7) exp_f = 7;
      chk("busy",      busy1,  (c <= 16));
      chk("done",      done1,  (c == 17));
      chk("res_valid", valid1, exp_v);
      chk("alu_a",     alu_a1, v.a);
      chk("alu_b",     alu_b1, v.b);
      chk("alu_f",     alu_f1, exp_f);
      if (exp_v) begin
        chk("res_f", res_f1, (c - 3) / 2);
        chk("res_y", res_y1, v.y[(c - 3) / 2]);
      end
      if (c == 17) chk("checksum", cks1, v.cks);
      // drive for the next edge
      start1 = 1'b0;
      if (v.ign != 0 && c == v.ign) begin
        start1 = 1'b1; a1 = 4'd0; b1 = 4'd0;
      end
    end
  endtask

  initial begin
    bit seen_done;
    bit got;

    tbl[0] = '{a: 4'd1,  b: 4'd2,  ign: 0,
               y: {4'd10, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3},   cks: 4'h8};
    tbl[1] = '{a: 4'd15, b: 4'd15, ign: 0,
               y: {4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd15, 4'd14},  cks: 4'h0};
    tbl[2] = '{a: 4'd1,  b: 4'd2,  ign: 6,
               y: {4'd10, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3},   cks: 4'h8};
    tbl[3] = '{a: 4'd3,  b: 4'd9,  ign: 0,
               y: {4'd3, 4'd2, 4'd1, 4'd0, 4'd15, 4'd14, 4'd13, 4'd12}, cks: 4'h0};
    tbl[4] = '{a: 4'd5,  b: 4'd0,  ign: 0,
               y: {4'd12, 4'd11, 4'd10, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5},  cks: 4'h8};

    rst = 1'b0; start1 = 1'b0; a1 = '0; b1 = '0;
    start2 = 1'b0; a2 = '0; b2 = '0;
    #1 rst = 1'b1;
    #1 chk_zero1("reset");
    chk("reset2 busy", busy2, 0);
    chk("reset2 done", done2, 0);
    chk("reset2 checksum", cks2, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven sweeps
    for (int i = 0; i < 4; i++) run_sweep(tbl[i]);

    // Asynchronous reset in the middle of cycle 8 of a sweep
    @(negedge clk);
    start1 = 1'b1; a1 = 4'd7; b1 = 4'd7;                // cycle 0
    @(negedge clk);
    start1 = 1'b0;                                      // cycle 1
    repeat (7) @(negedge clk);                          // cycle 8
    chk("pre-reset busy", busy1, 1);
    #2 rst = 1'b1;
    #1 chk_zero1("midsweep reset");
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done1 || busy1) seen_done = 1'b1;
    end
    chk("no done after abort", seen_done, 0);

    // Fresh sweep after the abort
    run_sweep(tbl[4]);

    // SETTLE=1, start held high: back-to-back sweeps
    @(negedge clk);
    start2 = 1'b1; a2 = 4'd1; b2 = 4'd2;                // cycle 0
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      chk("s1 busy",      busy2,  (c <= 8));
      chk("s1 done",      done2,  (c == 9));
      chk("s1 res_valid", valid2, (c >= 2));
      chk("s1 alu_f",     alu_f2, (c - 1 > 7) ? 7 : c - 1);
      if (c >= 2) begin
        chk("s1 res_f", res_f2, c - 2);
        chk("s1 res_y", res_y2, tbl[0].y[c - 2]);
      end
      if (c == 9) begin
        chk("s1 checksum", cks2, 4'h8);
        a2 = 4'd4; b2 = 4'd5;                           // picked up by the back-to-back start
      end
    end
    @(negedge clk);                                     // cycle 10
    chk("b2b busy",      busy2,  1);
    chk("b2b alu_a",     alu_a2, 4);
    chk("b2b alu_b",     alu_b2, 5);
    chk("b2b alu_f",     alu_f2, 0);
    chk("b2b res_valid", valid2, 0);
    chk("b2b done",      done2,  0);
    start2 = 1'b0;
    @(negedge clk);                                     // cycle 11
    chk("b2b first valid", valid2, 1);
    chk("b2b first res_f", res_f2, 0);
    chk("b2b first res_y", res_y2, 9);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (done2) got = 1'b1;
    end
    chk("b2b done seen", got, 1);
    if (got) chk("b2b checksum", cks2, 4'h8);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_barrido.md
# alu_barrido

Hardware sweep controller for the 4-bit ALU: it drives the ALU's A, B and F inputs, so it sits on the opposite side of the ALU interface. On `start` it latches one operand pair and steps F through all eight codes, 000 to 111. For each code it waits a programmable settle time, samples Y, and reports it with a one-cycle valid strobe. At the end of the sweep it emits a `done` pulse together with an XOR checksum of the eight results, so the ALU can be exercised on-chip without a simulator bench.

## Interface
- `W`, default 4: operand and result width; must match the ALU.
- `SETTLE`, default 2: cycles F is held before Y is sampled; legal range 1..15.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: sweep request; sampled only while idle.
- `a_in` in W: operand A, latched when `start` is accepted.
- `b_in` in W: operand B, latched when `start` is accepted.
- `busy` out 1: high while a sweep is in progress.
- `alu_a` out W: drives ALU input A.
- `alu_b` out W: drives ALU input B.
- `alu_f` out 3: drives ALU input F.
- `alu_y` in W: ALU output Y.
- `res_valid` out 1: one-cycle strobe marking a new result.
- `res_f` out 3: F code of the current result.
- `res_y` out W: sampled Y for that F code.
- `done` out 1: one-cycle pulse marking sweep completion.
- `checksum` out W: XOR of all eight `res_y` values of the last sweep.

## Operation
- **States:** IDLE, WAIT.
- **IDLE**
  - If `start`=1 on an edge: `alu_a`<=`a_in`, `alu_b`<=`b_in`, `alu_f`<=0, `cnt`<=0, `checksum`<=0, `busy`<=1, go to WAIT.
  - Otherwise all outputs hold.
- **WAIT**, on every edge:
  - If `cnt`!=SETTLE-1: `cnt`<=`cnt`+1.
  - If `cnt`==SETTLE-1 (sample edge): `res_y`<=`alu_y`, `res_f`<=`alu_f`, `res_valid`<=1, `checksum`<=`checksum`^`alu_y`.
    - If `alu_f`!=7: `alu_f`<=`alu_f`+1, `cnt`<=0.
    - If `alu_f`==7: `done`<=1, `busy`<=0, go to IDLE. The final XOR is included in `checksum` in the same cycle.
- **Pulses:** `res_valid` and `done` are registered and return to 0 on the next edge.
- **Hold values:**
  - `alu_a`, `alu_b` and `alu_f` hold their last values in IDLE; `alu_f` stays at 7 after a sweep.
  - `res_y`, `res_f` and `checksum` hold until overwritten.
- **Width:** `alu_f` increments without wrap inside a sweep. `checksum` is a plain W-bit XOR with no carry.
- **Start while busy:** `start` is ignored; operands are not re-latched.
- **Reset:** `rst` asserted at any time, including mid-sweep, forces IDLE immediately. All outputs and `cnt` go to 0. No `done` is produced for the aborted sweep.

## Timing
- **Reset values:** every output is 0 (`busy`, `alu_a`, `alu_b`, `alu_f`, `res_valid`, `res_f`, `res_y`, `done`, `checksum`).
- **Start and sampling** (cycle 0 = `start` high in IDLE):
  - Operands and F=0 are driven from cycle 1.
  - The F=k result has `res_valid` high in cycle 1+SETTLE·(k+1). With SETTLE=2: cycles 3, 5, …, 17.
- **Hold time:** F is held for exactly SETTLE cycles, and Y is sampled at the end of the last of them. The ALU must settle combinationally within SETTLE cycles.
- **Completion:**
  - `done` and the last `res_valid` (F=7) are high in the same cycle. With SETTLE=2 this is cycle 17.
  - `busy` is high from cycle 1 through the cycle before `done`, and low in the `done` cycle.
- **Back-to-back:** `start` high in the `done` cycle is accepted, so sweeps can run with no gap.
- **Sweep length:** total sweep latency is 8·SETTLE+1 cycles from `start` to `done`.

## Test plan
The bench connects a stub ALU with Y = (A+B+F) mod 16, using the default parameters W=4 and SETTLE=2.
- **Reset:** assert `rst` asynchronously mid-cycle → all outputs are 0 immediately, before the next edge.
- **Basic sweep:** A=1, B=2, `start` pulsed in cycle 0 → `res_valid` in cycles 3, 5, …, 17 with (`res_f`, `res_y`) = (0,3), (1,4), …, (7,10). `done`=1 and `checksum`=4'h8 in cycle 17; `busy` is high in cycles 1–16.
- **Wrap-around:** A=15, B=15 → `res_y` sequence 14, 15, 0, 1, 2, 3, 4, 5, and `checksum`=4'h0.
- **Ignored start:** `start` pulsed again in cycle 6 with A=0, B=0 → `alu_a`/`alu_b` stay 1/2 and the results are unchanged from the basic sweep.
- **Reset mid-sweep:** `rst` in cycle 8 → all outputs are 0, no `done`. A fresh `start` then completes normally with its own checksum.
- **SETTLE=1, back-to-back:** instantiate with SETTLE=1 and hold `start` high → `res_valid` in cycles 2–9, `done` in cycle 9, and a second sweep begins with operands driven in cycle 10.
